// File: rtl/raster_pkg.sv
// Shared geometry defaults, FSM state encoding and vertex packing for the
// raster scan controller and its pixel walker.
package raster_pkg;

    localparam int COORD_W  = 16;
    localparam int FRAC_W   = 6;
    localparam int INT_W    = COORD_W - FRAC_W;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BB,
        SCAN
    } raster_state_t;

    // v0x sits in the LSBs, matching the sipo output packing
    typedef struct packed {
        logic [COORD_W-1:0] v2y;
        logic [COORD_W-1:0] v1y;
        logic [COORD_W-1:0] v0y;
        logic [COORD_W-1:0] v2x;
        logic [COORD_W-1:0] v1x;
        logic [COORD_W-1:0] v0x;
    } tri_vtx_t;

endpackage

// File: rtl/raster_walker.sv
// Raster-order pixel counter: loads a clamped inclusive box and steps x then y,
// flagging the final pixel of the box.
module raster_walker #(
    parameter int INT_W = raster_pkg::INT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [INT_W-1:0] xs,
    input  logic [INT_W-1:0] xe,
    input  logic [INT_W-1:0] ys,
    input  logic [INT_W-1:0] ye,
    output logic [INT_W-1:0] x,
    output logic [INT_W-1:0] y,
    output logic             last
);

    logic [INT_W-1:0] x_q, x_d;
    logic [INT_W-1:0] y_q, y_d;
    logic [INT_W-1:0] xs_q, xe_q, ye_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            x_d = xs;
            y_d = ys;
        end else if (advance) begin
            if (x_q == xe_q) begin
                x_d = xs_q;
                y_d = y_q + INT_W'(1);
            end else begin
                x_d = x_q + INT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Bounds only matter once loaded, so they carry no reset
    always_ff @(posedge clk) begin
        if (load) begin
            xs_q <= xs;
            xe_q <= xe;
            ye_q <= ye;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/raster_scan_ctrl.sv
// Triangle sequencer: holds vertices for the bounding-box unit, samples and
// clamps the box, then streams every covered pixel in raster order.
module raster_scan_ctrl #(
    parameter int COORD_W  = raster_pkg::COORD_W,
    parameter int FRAC_W   = raster_pkg::FRAC_W,
    parameter int BBOX_LAT = 1,
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tri_valid,
    output logic                      tri_ready,
    input  logic [6*COORD_W-1:0]      tri_data,
    output logic [6*COORD_W-1:0]      bb_vtx,
    input  logic [COORD_W-1:0]        xmin,
    input  logic [COORD_W-1:0]        xmax,
    input  logic [COORD_W-1:0]        ymin,
    input  logic [COORD_W-1:0]        ymax,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [COORD_W-FRAC_W-1:0] pix_x,
    output logic [COORD_W-FRAC_W-1:0] pix_y,
    output logic                      pix_last,
    output logic                      tri_done,
    output logic                      busy
);

    import raster_pkg::*;

    localparam int INT_W = COORD_W - FRAC_W;
    localparam int LAT_W = (BBOX_LAT > 1) ? $clog2(BBOX_LAT) : 1;

    function automatic logic [INT_W-1:0] clamp_hi(input logic [INT_W-1:0] v,
                                                  input int lim);
        return (v > INT_W'(lim)) ? INT_W'(lim) : v;
    endfunction

    raster_state_t       state_q;
    logic [LAT_W-1:0]    lat_cnt_q;
    logic [6*COORD_W-1:0] bb_vtx_q;
    logic                tri_ready_q;
    logic                pix_valid_q;
    logic                tri_done_q;
    logic                busy_q;

    logic [INT_W-1:0] xs_c, xe_c, ys_c, ye_c;
    logic             box_empty, box_take, pix_hs;
    logic             wlk_load, wlk_adv, wlk_last;
    logic [INT_W-1:0] wlk_x, wlk_y;
    logic             unused_frac;

    // Floor to integer pixels; only the upper edges can leave the screen
    assign xs_c = xmin[COORD_W-1:FRAC_W];
    assign ys_c = ymin[COORD_W-1:FRAC_W];
    assign xe_c = clamp_hi(xmax[COORD_W-1:FRAC_W], SCREEN_W - 1);
    assign ye_c = clamp_hi(ymax[COORD_W-1:FRAC_W], SCREEN_H - 1);
    assign unused_frac = ^{xmin[FRAC_W-1:0], xmax[FRAC_W-1:0],
                           ymin[FRAC_W-1:0], ymax[FRAC_W-1:0]};

    assign box_empty = (xs_c > xe_c) || (ys_c > ye_c);
    assign box_take  = (state_q == WAIT_BB) && (lat_cnt_q == '0);
    assign pix_hs    = pix_valid_q && pix_ready;
    assign wlk_load  = box_take && !box_empty;
    assign wlk_adv   = pix_hs && !wlk_last;

    raster_walker #(
        .INT_W (INT_W)
    ) u_walker (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wlk_load),
        .advance (wlk_adv),
        .xs      (xs_c),
        .xe      (xe_c),
        .ys      (ys_c),
        .ye      (ye_c),
        .x       (wlk_x),
        .y       (wlk_y),
        .last    (wlk_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            bb_vtx_q    <= '0;
            tri_ready_q <= 1'b0;
            pix_valid_q <= 1'b0;
            tri_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            tri_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tri_ready_q <= 1'b1;
                    if (tri_valid && tri_ready_q) begin
                        bb_vtx_q    <= tri_data;
                        lat_cnt_q   <= LAT_W'(BBOX_LAT - 1);
                        state_q     <= WAIT_BB;
                        tri_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                WAIT_BB: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    end else if (box_empty) begin
                        state_q     <= IDLE;
                        tri_done_q  <= 1'b1;
                        tri_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q     <= SCAN;
                        pix_valid_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (pix_hs && wlk_last) begin
                        state_q     <= IDLE;
                        pix_valid_q <= 1'b0;
                        tri_done_q  <= 1'b1;
                        tri_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tri_ready = tri_ready_q;
    assign bb_vtx    = bb_vtx_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = wlk_x;
    assign pix_y     = wlk_y;
    assign pix_last  = pix_valid_q && wlk_last;
    assign tri_done  = tri_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: models the bounding-box unit from bb_vtx and
// scoreboards the pixel stream against an independently generated sequence.
module tb_raster_scan_ctrl;

    import raster_pkg::*;

    localparam int CW = 16;
    localparam int IW = 10;

    typedef struct packed {
        logic [IW-1:0] x;
        logic [IW-1:0] y;
        logic          last;
    } pix_t;

    typedef struct {
        tri_vtx_t v;
        int       mode;
        int       exp_n;
        string    name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tri_valid;
    logic          tri_ready;
    logic [6*CW-1:0] tri_data;
    logic [6*CW-1:0] bb_vtx;
    logic [CW-1:0] xmin, xmax, ymin, ymax;
    logic          pix_valid;
    logic          pix_ready;
    logic [IW-1:0] pix_x, pix_y;
    logic          pix_last;
    logic          tri_done;
    logic          busy;

    always #5 clk = ~clk;

    raster_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .tri_data  (tri_data),
        .bb_vtx    (bb_vtx),
        .xmin      (xmin),
        .xmax      (xmax),
        .ymin      (ymin),
        .ymax      (ymax),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .tri_done  (tri_done),
        .busy      (busy)
    );

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Combinational bounding-box environment (BBOX_LAT = 1)
    tri_vtx_t bv;
    assign bv   = bb_vtx;
    assign xmin = min3(bv.v0x, bv.v1x, bv.v2x);
    assign xmax = max3(bv.v0x, bv.v1x, bv.v2x);
    assign ymin = min3(bv.v0y, bv.v1y, bv.v2y);
    assign ymax = max3(bv.v0y, bv.v1y, bv.v2y);

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_c, pv_c, hs_c, dn_c, npix, nacc;
    pix_t exp_q[$];
    bit   pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic void chk(input string nm, input logic [127:0] act,
                                input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic tri_vtx_t mk(input logic [CW-1:0] x0, x1, y0, y1);
        tri_vtx_t v;
        v.v0x = x1;  v.v1x = x0;  v.v2x = x0;
        v.v0y = y0;  v.v1y = y1;  v.v2y = y0;
        return v;
    endfunction

    function automatic void push_exp(input tri_vtx_t v);
        int xs, xe, ys, ye;
        xs = int'(min3(v.v0x, v.v1x, v.v2x)) / 64;
        xe = int'(max3(v.v0x, v.v1x, v.v2x)) / 64;
        ys = int'(min3(v.v0y, v.v1y, v.v2y)) / 64;
        ye = int'(max3(v.v0y, v.v1y, v.v2y)) / 64;
        if (xe > 639) xe = 639;
        if (ye > 479) ye = 479;
        for (int yy = ys; yy <= ye; yy++)
            for (int xx = xs; xx <= xe; xx++)
                exp_q.push_back('{x: IW'(xx), y: IW'(yy), last: (xx == xe && yy == ye)});
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: scoreboard pops, stall stability, done-pulse shape, event times
    initial begin
        bit   prev_stall = 1'b0;
        bit   prev_done  = 1'b0;
        bit   prev_pv    = 1'b0;
        pix_t prev_pix   = '0;
        pix_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                prev_pv    = 1'b0;
            end else begin
                if (tri_valid && tri_ready) begin
                    acc_c = cyc;
                    nacc++;
                end
                if (pix_valid && !prev_pv) pv_c = cyc;
                if (prev_stall)
                    chk("stall_hold", {pix_valid, pix_x, pix_y, pix_last}, {1'b1, prev_pix});
                if (tri_done) begin
                    chk("done_shape", {prev_done, tri_ready, pix_valid}, 3'b010);
                    dn_c = cyc;
                end
                if (pix_valid && pix_ready) begin
                    npix++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL pix_extra: got (%0d,%0d) expected no pixel", pix_x, pix_y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pixel", {pix_x, pix_y, pix_last}, e);
                    end
                    if (pix_last) hs_c = cyc;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_pix   = '{x: pix_x, y: pix_y, last: pix_last};
                prev_done  = tri_done;
                prev_pv    = pix_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int k = 0;
        while (!tri_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", tri_ready, 1'b1);
    endtask

    task automatic drain(input int mode, input string nm);
        int k = 0;
        while (dn_c < 0 && k < 2000) begin
            pix_ready = (mode == 0) ? 1'b1 : pat[k % 6];
            @(posedge clk); #1;
            k++;
        end
        pix_ready = 1'b1;
        chk({nm, "_done_seen"}, dn_c >= 0, 1'b1);
    endtask

    task automatic run_vec(input vec_t tv);
        push_exp(tv.v);
        acc_c = -1; pv_c = -1; hs_c = -1; dn_c = -1; npix = 0;
        tri_data  = tv.v;
        tri_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        tri_valid = 1'b0;
        chk({tv.name, "_accept"}, {busy, tri_ready, bb_vtx}, {1'b1, 1'b0, tv.v});
        drain(tv.mode, tv.name);
        chk({tv.name, "_npix"}, npix, tv.exp_n);
        if (tv.exp_n == 0) begin
            chk({tv.name, "_empty_done_lat"}, dn_c - acc_c, 2);
        end else begin
            chk({tv.name, "_first_pix_lat"}, pv_c - acc_c, 2);
            chk({tv.name, "_done_after_last"}, dn_c - hs_c, 1);
        end
        chk({tv.name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    vec_t     vecs[7];
    tri_vtx_t va, vb;
    int       k;

    initial begin
        vecs[0] = '{mk(16'h00A0, 16'h0100, 16'h0040, 16'h00B0), 0, 6, "basic"};
        vecs[1] = '{mk(16'h00A0, 16'h0100, 16'h0040, 16'h00B0), 1, 6, "backpressure"};
        vecs[2] = '{mk(16'h9F00, 16'hAF00, 16'h00C0, 16'h00C0), 0, 4, "clamp_x"};
        vecs[3] = '{mk(16'hA280, 16'hA500, 16'h0040, 16'h0080), 0, 0, "empty_x"};
        vecs[4] = '{mk(16'h0140, 16'h0140, 16'h0080, 16'h0080), 0, 1, "single"};
        vecs[5] = '{mk(16'h0280, 16'h02C0, 16'h7780, 16'h7D00), 1, 4, "clamp_y"};
        vecs[6] = '{mk(16'h0040, 16'h0080, 16'h7A80, 16'h7D00), 0, 0, "empty_y"};

        rst_n     = 1'b0;
        tri_valid = 1'b1;
        tri_data  = vecs[0].v;
        pix_ready = 1'b1;
        acc_c = -1; pv_c = -1; hs_c = -1; dn_c = -1; npix = 0; nacc = 0;

        // Reset held with a triangle offered
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_outputs",
                {tri_ready, bb_vtx, pix_valid, pix_x, pix_y, pix_last, tri_done, busy}, '0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", {tri_ready, busy, bb_vtx}, {1'b1, 1'b0, 96'h0});
        chk("release_no_accept", nacc, 0);
        tri_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Single pixel followed by a triangle already waiting on tri_valid
        va = vecs[4].v;
        vb = vecs[0].v;
        push_exp(va);
        push_exp(vb);
        nacc = 0; hs_c = -1; dn_c = -1;
        tri_data  = va;
        tri_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        tri_data = vb;
        k = 0;
        while (nacc < 2 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        tri_valid = 1'b0;
        chk("b2b_second_accept", acc_c - hs_c, 1);
        chk("b2b_first_done", dn_c - hs_c, 1);
        chk("b2b_bb_vtx", bb_vtx, vb);
        dn_c = -1;
        drain(0, "b2b");
        chk("b2b_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a scan
        push_exp(vb);
        npix = 0; dn_c = -1;
        tri_data  = vb;
        tri_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        tri_valid = 1'b0;
        k = 0;
        while (npix < 2 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_two_pixels", npix, 2);
        rst_n     = 1'b0;
        pix_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_outputs", {pix_valid, tri_done, busy, tri_ready}, 4'b0000);
        exp_q.delete();
        rst_n     = 1'b1;
        pix_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_release", {tri_ready, tri_done, pix_valid}, 3'b100);
        chk("mid_rst_no_done", dn_c < 0, 1'b1);
        run_vec('{mk(16'h01C0, 16'h0200, 16'h00C0, 16'h00C0), 0, 2, "after_reset"});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/raster_scan_ctrl.md
# raster_scan_ctrl

Sequencer between the serial vertex loader (`sipo`) and the pixel pipeline. It accepts one packed triangle per handshake and holds the vertices stable on the `boundingbox` inputs. After the box latency it samples the box, clamps it to the screen, and walks every integer pixel in the box in raster order over a valid/ready stream. It owns the bounding-box datapath: only one triangle is in flight at a time.

## Interface
- `COORD_W`, 16: vertex/box coordinate width, unsigned fixed point.
- `FRAC_W`, 6: fractional bits; integer part is `INT_W = COORD_W-FRAC_W` (10).
- `BBOX_LAT`, 1: cycles from `bb_vtx` change to valid `xmin..ymax`; legal range ≥1.
- `SCREEN_W`, 640: screen width in pixels.
- `SCREEN_H`, 480: screen height in pixels.

Ports:
- `clk`, in, 1: single clock, all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `tri_valid`, in, 1: triangle available on `tri_data`.
- `tri_ready`, out, 1: controller idle and accepting.
- `tri_data`, in, 6*COORD_W: `{v2y,v1y,v0y,v2x,v1x,v0x}`, v0x in the LSBs (same packing as `sipo` out[95:0]).
- `bb_vtx`, out, 6*COORD_W: registered copy of the accepted `tri_data`; drives `boundingbox`.
- `xmin`, `xmax`, `ymin`, `ymax`, in, COORD_W each: box from `boundingbox`.
- `pix_valid`, out, 1: pixel coordinate presented.
- `pix_ready`, in, 1: downstream accepts the pixel.
- `pix_x`, `pix_y`, out, INT_W each: integer pixel coordinate.
- `pix_last`, out, 1: final pixel of the current triangle.
- `tri_done`, out, 1: one-cycle pulse when a triangle is retired.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT_BB, SCAN.
- IDLE:
  - `tri_ready=1`.
  - On `tri_valid & tri_ready`: latch `bb_vtx <= tri_data`, load `lat_cnt <= BBOX_LAT-1`, go to WAIT_BB.
- WAIT_BB:
  - While `lat_cnt≠0`, decrement.
  - At `lat_cnt==0`, sample the box:
    - `xs = xmin[COORD_W-1:FRAC_W]`, `xe = min(xmax[COORD_W-1:FRAC_W], SCREEN_W-1)`.
    - `ys = ymin[...]`, `ye = min(ymax[...], SCREEN_H-1)`.
    - Integer part is truncated (floor); ranges are inclusive.
  - If `xs>xe` or `ys>ye` (empty or off-screen): go to IDLE, pulse `tri_done`, emit no pixels.
  - Otherwise load `x=xs, y=ys` and go to SCAN.
- SCAN:
  - `pix_valid=1`, `pix_x=x`, `pix_y=y`, `pix_last=(x==xe && y==ye)`.
  - On `pix_valid & pix_ready`:
    - If `pix_last`: go to IDLE and pulse `tri_done`.
    - Else if `x==xe`: `x<=xs`, `y<=y+1`.
    - Else `x<=x+1`.
  - Comparisons are unsigned at INT_W bits. The clamp guarantees no wrap.
- `bb_vtx` changes only on triangle accept, so it stays stable through WAIT_BB and SCAN.
- Reset values (every output): `tri_ready=0` while `rst_n=0`, then 1 in the first cycle after release. `bb_vtx=0`, `pix_valid=0`, `pix_x=0`, `pix_y=0`, `pix_last=0`, `tri_done=0`, `busy=0`.
- Reset mid-operation: returns to IDLE, abandons the current triangle, and does not pulse `tri_done`.

## Timing
- Triangle accepted at cycle t:
  - `busy=1` from t+1.
  - Box sampled at t+BBOX_LAT.
  - First `pix_valid` at t+BBOX_LAT+1.
- Empty box: `tri_done` high at t+BBOX_LAT+1; `tri_ready` high the same cycle.
- Throughput: one pixel per cycle while `pix_ready=1`. While `pix_ready=0`, `pix_x`, `pix_y` and `pix_last` hold stable and `pix_valid` stays high.
- Final pixel handshake at cycle u:
  - `pix_valid=0`, `tri_done=1` and `tri_ready=1` all at u+1.
  - Next accept is possible at u+1.
- `tri_ready` never depends combinationally on `tri_valid`. `pix_valid` never depends on `pix_ready`.

## Structure
- Shared package `raster_pkg`:
  - `COORD_W`, `FRAC_W`, `INT_W`.
  - `SCREEN_W`, `SCREEN_H` defaults.
  - State enum `raster_state_t` {IDLE, WAIT_BB, SCAN}.
  - Packed struct `tri_vtx_t` matching the `tri_data` packing.
- One sub-module, `raster_walker`:
  - Holds the x/y counters and bounds.
  - Inputs: `load`, `advance`, `xs`, `xe`, `ys`, `ye`.
  - Outputs: `x`, `y`, `last`.
- FSM, latency counter, clamp and handshake logic stay in `raster_scan_ctrl`.

## Test plan
- Reset: hold `rst_n=0` 3 cycles with `tri_valid=1` → all outputs 0. `tri_ready=1` on the first cycle after release, and no accept occurs during reset.
- Basic box: xmin=0x00A0 (2.5), xmax=0x0100 (4.0), ymin=0x0040 (1.0), ymax=0x00B0 (2.75), `pix_ready=1` → pixels (2,1),(3,1),(4,1),(2,2),(3,2),(4,2) on consecutive cycles. First pixel at t+2 (BBOX_LAT=1). `pix_last` only on (4,2). `tri_done` pulses one cycle later.
- Backpressure: same box with `pix_ready` pattern 1,0,0,1,0,1… → identical pixel sequence, with outputs stable during every stall cycle.
- Clamp and empty:
  - xmax integer 700 → row ends at x=639.
  - xmin integer 650 → zero pixels, `tri_done` at t+2, `tri_ready` high the same cycle.
- Single pixel and back-to-back: xmin=xmax=0x0140, ymin=ymax=0x0080 → one pixel (5,2) with `pix_last=1`. A second triangle held on `tri_valid` is accepted exactly the cycle after that handshake.
- Reset mid-SCAN: assert `rst_n=0` after 2 of 6 pixels → next cycle `pix_valid=0`, no `tri_done`. A new triangle after release scans from its own (xs,ys).
